// File: rtl/i2c_master_fifo.sv
// Byte-oriented I2C master fed by a command FIFO. SCL is generated from clk in
// quarter-bit phases; SDA is open-drain (drives 0 or z only).
module i2c_master_fifo #(
    parameter int unsigned CLK_DIV    = 62,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STATE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         DIN,
    input  logic               cmd_start,
    input  logic               cmd_stop,
    input  logic               cmd_read,
    input  logic               cmd_nack,
    input  logic               copy_enable,
    output logic               fifo_full,
    output logic [7:0]         DOUT,
    output logic               rd_valid,
    output logic               busy,
    output logic               ack_err,
    output logic               overflow,
    output logic               i2c_scl,
    inout  wire                i2c_sda_io,
    output logic [STATE_W-1:0] i2c_state
);

    localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StBit   = 3'd2,
        StAck   = 3'd3,
        StStop  = 3'd4,
        StHold  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_q;
    logic [2:0]      r_bit;
    logic [2:0]      r_cmd;       // {stop, read, nack} of the byte in flight
    logic [7:0]      r_sh;
    logic            r_ack_bit;
    logic            r_scl;
    logic [7:0]      r_dout;
    logic            r_rd_valid;
    logic            r_ack_err;
    logic            r_overflow;
    logic [11:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic [11:0]     w_head;
    logic            w_running;
    logic            w_qend;
    logic            w_phase_end;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_proto_err;
    logic            w_nack_err;
    logic            w_rd_done;
    logic            w_scl;
    logic            w_sda_low;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_head       = r_mem[r_rptr];
    assign w_running    = (r_state != StIdle) && (r_state != StHold);
    assign w_qend       = (r_qcnt == QW'(CLK_DIV - 1));
    assign w_phase_end  = w_qend && (r_q == 2'd3);
    assign w_push       = copy_enable && (!w_fifo_full || w_pop) && !w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_proto_err  = 1'b0;
        w_nack_err   = 1'b0;
        w_rd_done    = 1'b0;
        w_scl        = 1'b1;
        w_sda_low    = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
                    if (w_head[11]) w_state_next = StStart;
                    else            w_proto_err  = 1'b1;
                end
            end
            StHold: begin
                w_scl = 1'b0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = w_head[11] ? StStart : StBit;
                end
            end
            StStart: begin
                w_scl     = (r_q == 2'd0) ? r_scl : (r_q != 2'd3);
                w_sda_low = r_q[1];
                if (w_phase_end) w_state_next = StBit;
            end
            StBit: begin
                w_scl     = r_q[1];
                w_sda_low = !r_cmd[1] && !r_sh[7];
                if (w_phase_end && (r_bit == 3'd7)) w_state_next = StAck;
            end
            StAck: begin
                w_scl     = r_q[1];
                w_sda_low = r_cmd[1] && !r_cmd[0];
                if (w_phase_end) begin
                    if (!r_cmd[1] && r_ack_bit) begin
                        w_nack_err   = 1'b1;
                        w_flush      = 1'b1;
                        w_state_next = StStop;
                    end else begin
                        w_rd_done = r_cmd[1];
                        if (r_cmd[2]) begin
                            w_state_next = StStop;
                        end else if (!w_fifo_empty && !w_head[11]) begin
                            // Chain straight into the next data byte; a repeated
                            // START goes through HOLD so SCL is low before it.
                            w_pop        = 1'b1;
                            w_state_next = StBit;
                        end else begin
                            w_state_next = StHold;
                        end
                    end
                end
            end
            StStop: begin
                w_scl     = (r_q != 2'd0);
                w_sda_low = (r_q != 2'd3);
                if (w_phase_end) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {cmd_start, cmd_stop, cmd_read, cmd_nack, DIN};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_qcnt     <= '0;
            r_q        <= '0;
            r_bit      <= '0;
            r_cmd      <= '0;
            r_sh       <= '0;
            r_ack_bit  <= 1'b0;
            r_scl      <= 1'b1;
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
            r_ack_err  <= 1'b0;
            r_overflow <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_scl      <= w_scl;
            r_rd_valid <= w_rd_done;
            if (w_running) begin
                r_qcnt <= w_qend ? '0 : r_qcnt + QW'(1);
                if (w_qend) r_q <= r_q + 2'd1;
            end else begin
                r_qcnt <= '0;
                r_q    <= '0;
            end
            if ((r_state == StBit) && w_phase_end) r_bit <= r_bit + 3'd1;
            if (w_pop) begin
                r_cmd <= w_head[10:8];
                r_sh  <= w_head[7:0];
            end else if ((r_state == StBit) && w_qend) begin
                if (r_cmd[1] && (r_q == 2'd2))       r_sh <= {r_sh[6:0], i2c_sda_io};
                else if (!r_cmd[1] && (r_q == 2'd3)) r_sh <= {r_sh[6:0], 1'b0};
            end
            if ((r_state == StAck) && w_qend && (r_q == 2'd2)) r_ack_bit <= i2c_sda_io;
            if (w_rd_done) r_dout <= r_sh;
            if (w_proto_err || w_nack_err) r_ack_err <= 1'b1;
            if (copy_enable && w_fifo_full && !w_pop) r_overflow <= 1'b1;
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            end
        end
    end

    assign i2c_sda_io = w_sda_low ? 1'b0 : 1'bz;
    assign i2c_scl    = w_scl;
    assign fifo_full  = w_fifo_full;
    assign DOUT       = r_dout;
    assign rd_valid   = r_rd_valid;
    assign busy       = !w_fifo_empty || (r_state != StIdle);
    assign ack_err    = r_ack_err;
    assign overflow   = r_overflow;
    assign i2c_state  = STATE_W'(r_state);

endmodule

// File: tb/tb_i2c_master_fifo.sv
// Bench for i2c_master_fifo: bus monitor plus slave model, scoreboard queues for
// written bytes, read data and master ACK bits.
module tb_i2c_master_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = '0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_nack = 1'b0;
    logic       copy_enable = 1'b0;
    logic       fifo_full;
    logic [7:0] dout;
    logic       rd_valid;
    logic       busy;
    logic       ack_err;
    logic       overflow;
    logic       scl;
    logic [7:0] state;
    wire        sda;

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    int n_stop = 0;
    int n_rdv = 0;
    int busy_cycles = 0;

    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic       exp_mack[$];

    logic       ack_en = 1'b1;
    logic [7:0] rd_data = '0;
    logic       slave_drv = 1'b0;
    int         mon_bitcnt = 0;
    logic [7:0] mon_sh = '0;
    logic       mon_first = 1'b0;
    logic       mon_rd = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;

    pullup (sda);
    assign sda = slave_drv ? 1'b0 : 1'bz;

    i2c_master_fifo #(
        .CLK_DIV   (4),
        .FIFO_DEPTH(4),
        .STATE_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .DIN        (din),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_read   (cmd_read),
        .cmd_nack   (cmd_nack),
        .copy_enable(copy_enable),
        .fifo_full  (fifo_full),
        .DOUT       (dout),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .ack_err    (ack_err),
        .overflow   (overflow),
        .i2c_scl    (scl),
        .i2c_sda_io (sda),
        .i2c_state  (state)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bus monitor and slave: edges are judged from values sampled on negedge clk.
    always @(negedge clk) begin
        if (reset) begin
            mon_bitcnt = 0;
            mon_first  = 1'b0;
            mon_rd     = 1'b0;
            slave_drv  = 1'b0;
            scl_p      = 1'b1;
            sda_p      = 1'b1;
        end else begin
            if (scl_p && scl && sda_p && !sda) begin
                n_start++;
                mon_bitcnt = 0;
                mon_first  = 1'b1;
                mon_rd     = 1'b0;
                slave_drv  = 1'b0;
            end else if (scl_p && scl && !sda_p && sda) begin
                n_stop++;
                mon_bitcnt = 0;
                mon_first  = 1'b0;
                mon_rd     = 1'b0;
                slave_drv  = 1'b0;
            end else if (!scl_p && scl) begin
                if (mon_bitcnt < 8) begin
                    mon_sh = {mon_sh[6:0], sda};
                    mon_bitcnt++;
                    if (mon_bitcnt == 8 && !mon_rd) begin
                        if (exp_wr.size() == 0) check_eq("wr_unexpected", 1, 0);
                        else check_eq("wr_byte", 32'(mon_sh), 32'(exp_wr.pop_front()));
                    end
                end else begin
                    mon_bitcnt = 0;
                    if (mon_rd) begin
                        if (exp_mack.size() == 0) check_eq("mack_unexpected", 1, 0);
                        else check_eq("master_ack", 32'(sda), 32'(exp_mack.pop_front()));
                        if (sda) mon_rd = 1'b0;
                    end else if (mon_first && mon_sh[0] && !sda) begin
                        mon_rd = 1'b1;
                    end
                    mon_first = 1'b0;
                end
            end else if (scl_p && !scl) begin
                if (mon_rd) slave_drv = (mon_bitcnt < 8) ? !rd_data[7 - mon_bitcnt] : 1'b0;
                else        slave_drv = (mon_bitcnt == 8) && ack_en;
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            n_rdv++;
            if (exp_rd.size() == 0) check_eq("rd_unexpected", 1, 0);
            else check_eq("dout", 32'(dout), 32'(exp_rd.pop_front()));
        end
        if (!reset && state != 8'd0) busy_cycles++;
    end

    task automatic do_reset(input logic ack);
        @(negedge clk);
        reset = 1'b1;
        copy_enable = 1'b0;
        ack_en = ack;
        repeat (3) @(negedge clk);
        exp_wr.delete();
        exp_rd.delete();
        exp_mack.delete();
        n_start = 0;
        n_stop = 0;
        n_rdv = 0;
        busy_cycles = 0;
        reset = 1'b0;
    endtask

    task automatic push(input logic s, input logic p, input logic r, input logic n,
                        input logic [7:0] d);
        @(negedge clk);
        cmd_start = s;
        cmd_stop = p;
        cmd_read = r;
        cmd_nack = n;
        din = d;
        copy_enable = 1'b1;
        @(negedge clk);
        copy_enable = 1'b0;
    endtask

    task automatic wr(input logic s, input logic p, input logic [7:0] d);
        exp_wr.push_back(d);
        push(s, p, 1'b0, 1'b0, d);
    endtask

    task automatic rd(input logic n, input logic p, input logic [7:0] d);
        exp_rd.push_back(d);
        exp_mack.push_back(n);
        push(1'b0, p, 1'b1, n, 8'h00);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq(tag, 32'(busy), 0);
    endtask

    initial begin
        do_reset(1'b1);
        check_eq("rst_scl", 32'(scl), 1);
        check_eq("rst_sda", 32'(sda), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_rd_valid", 32'(rd_valid), 0);
        check_eq("rst_ack_err", 32'(ack_err), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_fifo_full", 32'(fifo_full), 0);

        // Three-byte write with START and STOP
        wr(1'b1, 1'b0, 8'h70);
        wr(1'b0, 1'b0, 8'h25);
        wr(1'b0, 1'b1, 8'hAA);
        wait_idle("t1_idle");
        check_eq("t1_cycles", busy_cycles, 464);
        check_eq("t1_ack_err", 32'(ack_err), 0);
        check_eq("t1_starts", n_start, 1);
        check_eq("t1_stops", n_stop, 1);
        check_eq("t1_pending", exp_wr.size(), 0);

        // No slave: NACK on address flushes the remaining byte
        do_reset(1'b0);
        wr(1'b1, 1'b0, 8'h70);
        push(1'b0, 1'b1, 1'b0, 1'b0, 8'h25);
        wait_idle("t2_idle");
        check_eq("t2_ack_err", 32'(ack_err), 1);
        check_eq("t2_cycles", busy_cycles, 176);
        check_eq("t2_stops", n_stop, 1);
        check_eq("t2_pending", exp_wr.size(), 0);

        // Address + single read with master NACK
        do_reset(1'b1);
        rd_data = 8'h42;
        wr(1'b1, 1'b0, 8'h71);
        rd(1'b1, 1'b1, 8'h42);
        wait_idle("t3_idle");
        check_eq("t3_rdv_count", n_rdv, 1);
        check_eq("t3_dout", 32'(dout), 32'h42);
        check_eq("t3_rd_pending", exp_rd.size() + exp_mack.size(), 0);
        check_eq("t3_stops", n_stop, 1);
        check_eq("t3_ack_err", 32'(ack_err), 0);

        // Write register address, repeated START, read
        do_reset(1'b1);
        rd_data = 8'hA5;
        wr(1'b1, 1'b0, 8'h70);
        wr(1'b0, 1'b0, 8'h01);
        wr(1'b1, 1'b0, 8'h71);
        rd(1'b1, 1'b1, 8'hA5);
        wait_idle("t4_idle");
        check_eq("t4_starts", n_start, 2);
        check_eq("t4_stops", n_stop, 1);
        check_eq("t4_rdv_count", n_rdv, 1);
        check_eq("t4_dout", 32'(dout), 32'hA5);
        check_eq("t4_pending", exp_wr.size() + exp_rd.size(), 0);

        // Fill FIFO while the bus is busy, then overflow
        do_reset(1'b1);
        wr(1'b1, 1'b0, 8'h70);
        for (int i = 0; i < 50; i++) begin
            if (state != 8'd0) break;
            @(negedge clk);
        end
        check_eq("t5_started", 32'(state != 8'd0), 1);
        wr(1'b0, 1'b0, 8'h11);
        wr(1'b0, 1'b0, 8'h22);
        wr(1'b0, 1'b0, 8'h33);
        wr(1'b0, 1'b1, 8'h44);
        check_eq("t5_full", 32'(fifo_full), 1);
        check_eq("t5_ovf_before", 32'(overflow), 0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        check_eq("t5_ovf_after", 32'(overflow), 1);
        check_eq("t5_full_after", 32'(fifo_full), 1);
        wait_idle("t5_idle");
        check_eq("t5_cycles", busy_cycles, 752);
        check_eq("t5_pending", exp_wr.size(), 0);
        check_eq("t5_ack_err", 32'(ack_err), 0);

        // Entry without START from IDLE is discarded as a protocol error
        do_reset(1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
        wait_idle("tp_idle");
        check_eq("tp_ack_err", 32'(ack_err), 1);
        check_eq("tp_cycles", busy_cycles, 0);
        check_eq("tp_starts", n_start, 0);

        // One-cycle reset in the middle of a written byte
        do_reset(1'b1);
        wr(1'b1, 1'b0, 8'h70);
        wr(1'b0, 1'b0, 8'h33);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (mon_bitcnt == 3) break;
        end
        check_eq("t6_reach_bit3", mon_bitcnt, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_scl", 32'(scl), 1);
        check_eq("t6_sda", 32'(sda), 1);
        check_eq("t6_busy", 32'(busy), 0);
        check_eq("t6_state", 32'(state), 0);
        check_eq("t6_full", 32'(fifo_full), 0);
        check_eq("t6_flags", {30'd0, ack_err, overflow}, 0);
        repeat (20) @(negedge clk);
        check_eq("t6_stay_idle", {busy, state}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
